// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared sizes and types for the register status file
package regfile_pkg;
   localparam int D_WIDTH_DEF   = 31;
   localparam int A_WIDTH_DEF   = 4;
   localparam int ROB_WIDTH_DEF = 3;
   localparam int REG_COUNT     = 2 ** (A_WIDTH_DEF + 1);

   typedef logic [A_WIDTH_DEF:0]   reg_addr_t;
   typedef logic [D_WIDTH_DEF:0]   reg_data_t;
   typedef logic [ROB_WIDTH_DEF:0] rob_tag_t;

   typedef struct packed {
      logic     busy;
      rob_tag_t tag;
   } reg_status_t;
endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one combinational read port with x0 masking and commit bypass
module rf_read_port
   import regfile_pkg::*;
#(
   parameter int D_WIDTH   = D_WIDTH_DEF,
   parameter int A_WIDTH   = A_WIDTH_DEF,
   parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
   input  logic [A_WIDTH:0]   address,
   input  logic [D_WIDTH:0]   stored_value,
   input  logic               stored_busy,
   input  logic [ROB_WIDTH:0] stored_tag,
   input  logic               commit_write,
   input  logic [A_WIDTH:0]   wraddress,
   input  logic [D_WIDTH:0]   wdata,
   input  logic [ROB_WIDTH:0] commit_tag,
   output logic [D_WIDTH:0]   value,
   output logic               busy,
   output logic [ROB_WIDTH:0] tag
);
   logic hit;

   always_comb begin
      hit   = commit_write && (wraddress == address);
      value = '0;
      busy  = 1'b0;
      tag   = '0;
      if (address != '0) begin
         value = hit ? wdata : stored_value;
         // A commit retiring the current producer makes the register ready this same cycle.
         busy  = stored_busy && !(hit && (stored_tag == commit_tag));
         tag   = stored_tag;
      end
   end
endmodule

// File: rtl/register_status_file.sv
// rtl/register_status_file.sv - committed register values plus per-register rename status
module register_status_file
   import regfile_pkg::*;
#(
   parameter int D_WIDTH   = D_WIDTH_DEF,
   parameter int A_WIDTH   = A_WIDTH_DEF,
   parameter int ROB_WIDTH = ROB_WIDTH_DEF,
   parameter int NUM_READ  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [A_WIDTH:0]   address [NUM_READ],
   output logic [D_WIDTH:0]   regValue [NUM_READ],
   output logic [NUM_READ-1:0] regBusy,
   output logic [ROB_WIDTH:0] regTag [NUM_READ],
   input  logic               dispatchValid,
   input  logic [A_WIDTH:0]   dispatchAddr,
   input  logic [ROB_WIDTH:0] dispatchTag,
   input  logic               validCommit,
   input  logic               regWrite,
   input  logic [A_WIDTH:0]   wraddress,
   input  logic [D_WIDTH:0]   wdata,
   input  logic [ROB_WIDTH:0] commitTag,
   input  logic               flush,
   output logic [A_WIDTH+1:0] busyCount
);
   localparam int NREGS = 2 ** (A_WIDTH + 1);
   localparam logic [A_WIDTH+1:0] COUNT_MAX = (A_WIDTH + 2)'(NREGS - 1);
   localparam logic [A_WIDTH+1:0] COUNT_ONE = (A_WIDTH + 2)'(1);

   logic [D_WIDTH:0]   data [NREGS];
   logic [NREGS-1:0]   busy;
   logic [ROB_WIDTH:0] tag [NREGS];

   logic commit_we;
   logic dispatch_en;
   logic commit_clear;
   logic count_inc;

   always_comb begin
      commit_we    = validCommit && regWrite && (wraddress != '0);
      dispatch_en  = dispatchValid && (dispatchAddr != '0) && !flush;
      // A same-cycle rename of the committing register keeps it busy under the new producer.
      commit_clear = commit_we && busy[wraddress] && (tag[wraddress] == commitTag)
                     && !(dispatch_en && (dispatchAddr == wraddress));
      count_inc    = dispatch_en && !busy[dispatchAddr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) begin
            data[r] <= '0;
            tag[r]  <= '0;
         end
         busy      <= '0;
         busyCount <= '0;
      end else begin
         if (commit_we) begin
            data[wraddress] <= wdata;
         end
         if (flush) begin
            busy      <= '0;
            busyCount <= '0;
         end else begin
            if (commit_clear) begin
               busy[wraddress] <= 1'b0;
            end
            if (dispatch_en) begin
               busy[dispatchAddr] <= 1'b1;
               tag[dispatchAddr]  <= dispatchTag;
            end
            if (count_inc && !commit_clear && busyCount != COUNT_MAX) begin
               busyCount <= busyCount + COUNT_ONE;
            end else if (commit_clear && !count_inc && busyCount != '0) begin
               busyCount <= busyCount - COUNT_ONE;
            end
         end
      end
   end

   for (genvar i = 0; i < NUM_READ; i++) begin : g_read
      rf_read_port #(
         .D_WIDTH   (D_WIDTH),
         .A_WIDTH   (A_WIDTH),
         .ROB_WIDTH (ROB_WIDTH)
      ) u_port (
         .address      (address[i]),
         .stored_value (data[address[i]]),
         .stored_busy  (busy[address[i]]),
         .stored_tag   (tag[address[i]]),
         .commit_write (commit_we),
         .wraddress    (wraddress),
         .wdata        (wdata),
         .commit_tag   (commitTag),
         .value        (regValue[i]),
         .busy         (regBusy[i]),
         .tag          (regTag[i])
      );
   end
endmodule

// File: tb/tb_register_status_file.sv
// tb/tb_register_status_file.sv - randomized and directed bench against a behavioural register model
module tb_register_status_file;
   localparam int D_WIDTH = 31, A_WIDTH = 4, ROB_WIDTH = 3, NUM_READ = 2;

   logic                clk, rst_n;
   logic [A_WIDTH:0]    address [NUM_READ];
   logic [D_WIDTH:0]    regValue [NUM_READ];
   logic [NUM_READ-1:0] regBusy;
   logic [ROB_WIDTH:0]  regTag [NUM_READ];
   logic                dispatchValid, validCommit, regWrite, flush;
   logic [A_WIDTH:0]    dispatchAddr, wraddress;
   logic [ROB_WIDTH:0]  dispatchTag, commitTag;
   logic [D_WIDTH:0]    wdata;
   logic [A_WIDTH+1:0]  busyCount;

   register_status_file #(
      .D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH), .ROB_WIDTH(ROB_WIDTH), .NUM_READ(NUM_READ)
   ) dut (
      .clk(clk), .rst_n(rst_n), .address(address), .regValue(regValue), .regBusy(regBusy),
      .regTag(regTag), .dispatchValid(dispatchValid), .dispatchAddr(dispatchAddr),
      .dispatchTag(dispatchTag), .validCommit(validCommit), .regWrite(regWrite),
      .wraddress(wraddress), .wdata(wdata), .commitTag(commitTag), .flush(flush),
      .busyCount(busyCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Architectural view: committed values, which registers await a producer, and which one.
   logic [D_WIDTH:0]   m_data [32];
   bit                 m_busy [32];
   logic [ROB_WIDTH:0] m_tag  [32];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         m_data[r] = '0;
         m_busy[r] = 0;
         m_tag[r]  = '0;
      end
   endtask

   function automatic int busy_total();
      int n = 0;
      for (int r = 1; r < 32; r++) n += int'(m_busy[r]);
      return n;
   endfunction

   task automatic set_idle();
      for (int i = 0; i < NUM_READ; i++) address[i] = '0;
      dispatchValid = 0; dispatchAddr = '0; dispatchTag = '0;
      validCommit = 0; regWrite = 0; wraddress = '0; wdata = '0; commitTag = '0;
      flush = 0;
   endtask

   task automatic settle();
      bit writes;
      #1;
      writes = validCommit && regWrite && (wraddress != 0);
      for (int i = 0; i < NUM_READ; i++) begin
         int a = int'(address[i]);
         logic [D_WIDTH:0] ev;
         bit eb;
         if (a == 0) begin
            ev = '0; eb = 0;
         end else begin
            ev = (writes && int'(wraddress) == a) ? wdata : m_data[a];
            eb = m_busy[a] && !(writes && int'(wraddress) == a && m_tag[a] == commitTag);
         end
         check($sformatf("value[%0d]@x%0d", i, a), 64'(regValue[i]), 64'(ev));
         check($sformatf("busy[%0d]@x%0d", i, a), 64'(regBusy[i]), 64'(eb));
         if (a == 0) check($sformatf("tag[%0d]@x0", i), 64'(regTag[i]), 64'd0);
         else if (eb) check($sformatf("tag[%0d]@x%0d", i, a), 64'(regTag[i]), 64'(m_tag[a]));
      end
      check("busyCount", 64'(busyCount), 64'(busy_total()));
   endtask

   task automatic advance();
      int wa = int'(wraddress);
      int da = int'(dispatchAddr);
      bit de = dispatchValid && da != 0 && !flush;
      @(posedge clk);
      if (validCommit && regWrite && wa != 0) begin
         m_data[wa] = wdata;
         if (m_busy[wa] && m_tag[wa] == commitTag) m_busy[wa] = 0;
      end
      if (flush) begin
         for (int r = 0; r < 32; r++) m_busy[r] = 0;
      end else if (de) begin
         m_busy[da] = 1;
         m_tag[da]  = dispatchTag;
      end
      @(negedge clk);
   endtask

   task automatic do_commit(input int a, input logic [D_WIDTH:0] d, input int t);
      set_idle();
      validCommit = 1; regWrite = 1; wraddress = A_WIDTH'(a); wdata = d; commitTag = ROB_WIDTH'(t);
   endtask

   task automatic do_dispatch(input int a, input int t);
      set_idle();
      dispatchValid = 1; dispatchAddr = (A_WIDTH + 1)'(a); dispatchTag = (ROB_WIDTH + 1)'(t);
   endtask

   initial begin
      set_idle();
      model_reset();
      rst_n = 0;
      repeat (3) @(negedge clk);
      rst_n = 1;
      address[0] = 5'd4; address[1] = 5'd31;
      settle(); advance();

      // Commit write-through and x0 write ignore
      do_commit(4, 60, 0); settle(); advance();
      do_commit(9, 80, 0); settle(); advance();
      do_commit(3, 9, 0); address[0] = 5'd3; address[1] = 5'd4;
      settle();
      check("t2_wt_x3", 64'(regValue[0]), 64'd9);
      check("t2_x4", 64'(regValue[1]), 64'd60);
      advance();
      do_commit(0, 5, 0); address[0] = 5'd0; settle(); advance();
      set_idle(); address[1] = 5'd0; settle();
      check("t2_x0", 64'(regValue[1]), 64'd0);
      advance();

      // Dispatch then commit of the matching producer
      do_dispatch(5, 2); settle(); advance();
      set_idle(); address[0] = 5'd5; settle();
      check("t3_busy", 64'(regBusy[0]), 64'd1);
      check("t3_tag", 64'(regTag[0]), 64'd2);
      check("t3_count", 64'(busyCount), 64'd1);
      advance();
      do_commit(5, 7, 2); address[0] = 5'd5; settle();
      check("t3_bypass_busy", 64'(regBusy[0]), 64'd0);
      check("t3_bypass_val", 64'(regValue[0]), 64'd7);
      advance();
      set_idle(); settle();
      check("t3_count_after", 64'(busyCount), 64'd0);
      advance();

      // Stale commit must not clear a renamed register
      do_dispatch(5, 2); settle(); advance();
      do_dispatch(5, 6); settle(); advance();
      do_commit(5, 11, 2); settle(); advance();
      set_idle(); address[0] = 5'd5; settle();
      check("t4_val", 64'(regValue[0]), 64'd11);
      check("t4_busy", 64'(regBusy[0]), 64'd1);
      check("t4_tag", 64'(regTag[0]), 64'd6);
      check("t4_count", 64'(busyCount), 64'd1);
      advance();

      // Same-cycle clear and rename of x5: rename wins
      do_commit(5, 13, 6); dispatchValid = 1; dispatchAddr = 5'd5; dispatchTag = 3'd3;
      settle(); advance();
      set_idle(); address[0] = 5'd5; settle();
      check("t5_busy", 64'(regBusy[0]), 64'd1);
      check("t5_tag", 64'(regTag[0]), 64'd3);
      check("t5_count", 64'(busyCount), 64'd1);
      advance();

      // Flush with concurrent dispatch and commit
      for (int r = 1; r <= 3; r++) begin
         do_dispatch(r, r); settle(); advance();
      end
      do_commit(2, 42, 7); flush = 1; dispatchValid = 1; dispatchAddr = 5'd7; dispatchTag = 3'd4;
      settle(); advance();
      set_idle(); address[0] = 5'd7; address[1] = 5'd2; settle();
      check("t6_x7_busy", 64'(regBusy[0]), 64'd0);
      check("t6_x2_busy", 64'(regBusy[1]), 64'd0);
      check("t6_x2_val", 64'(regValue[1]), 64'd42);
      check("t6_count", 64'(busyCount), 64'd0);
      advance();

      // Fill every register, then rename again and target x0
      for (int r = 1; r < 32; r++) begin
         do_dispatch(r, r % 8); settle(); advance();
      end
      do_dispatch(0, 1); settle(); advance();
      do_dispatch(17, 5); settle(); advance();
      set_idle(); settle();
      check("full_count", 64'(busyCount), 64'd31);

      // Asynchronous reset mid-cycle
      address[0] = 5'd9; address[1] = 5'd4;
      #2 rst_n = 0;
      #1;
      check("rst_val0", 64'(regValue[0]), 64'd0);
      check("rst_val1", 64'(regValue[1]), 64'd0);
      check("rst_busy", 64'(regBusy), 64'd0);
      check("rst_count", 64'(busyCount), 64'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      settle(); advance();

      for (int n = 0; n < 400; n++) begin
         int wa;
         for (int i = 0; i < NUM_READ; i++) address[i] = (A_WIDTH + 1)'($urandom_range(0, 7));
         dispatchValid = 1'($urandom);
         dispatchAddr  = (A_WIDTH + 1)'($urandom_range(0, 7));
         dispatchTag   = (ROB_WIDTH + 1)'($urandom);
         validCommit   = 1'($urandom);
         regWrite      = ($urandom % 4) != 0;
         wa            = int'($urandom_range(0, 7));
         wraddress     = (A_WIDTH + 1)'(wa);
         wdata         = $urandom;
         commitTag     = ($urandom % 2 != 0) ? m_tag[wa] : (ROB_WIDTH + 1)'($urandom);
         flush         = ($urandom % 20) == 0;
         settle(); advance();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
